// File: rtl/alu_pkg.sv
// Shared opcode values, decoded operation kinds, FSM states and the flag bundle
// used by the pipelined ALU and its sequential multiplier.
package alu_pkg;

    localparam int OPC_ADD  = 0;
    localparam int OPC_SUB  = 1;
    localparam int OPC_MUL  = 2;
    localparam int OPC_EQ   = 3;
    localparam int OPC_GT   = 4;
    localparam int OPC_ADDI = 9;
    localparam int OPC_SUBI = 10;
    localparam int OPC_MOV  = 11;

    // Immediate forms share the datapath of their register counterparts.
    typedef enum logic [2:0] {
        OP_ADD,
        OP_SUB,
        OP_MUL,
        OP_EQ,
        OP_GT,
        OP_MOV,
        OP_ILLEGAL
    } op_kind_e;

    typedef enum logic {
        ST_IDLE,
        ST_MUL_BUSY
    } state_e;

    typedef struct packed {
        logic overflow;
        logic carry;
        logic zero;
        logic sign;
        logic parity;
        logic illegal;
    } flags_t;

    localparam flags_t FLAGS_RESET = '{
        overflow: 1'b0,
        carry:    1'b0,
        zero:     1'b1,
        sign:     1'b0,
        parity:   1'b0,
        illegal:  1'b0
    };

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add signed multiplier: one partial product per step on operand
// magnitudes, with the sign applied to the finished product.
module seq_multiplier #(
    parameter int W = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic           step_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [2*W-1:0] product_o
);

    localparam int CNT_W = (W > 2) ? $clog2(W) : 1;

    logic             busy_q;
    logic             neg_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2*W-1:0]   mcand_q;
    logic [W-1:0]     mplier_q;
    logic [2*W-1:0]   acc_q;
    logic [2*W-1:0]   acc_step;

    // The most negative operand still has a representable unsigned magnitude.
    function automatic logic [W-1:0] magnitude(input logic [W-1:0] x);
        return x[W-1] ? (~x + 1'b1) : x;
    endfunction

    // done_o flags the final step; product_o already includes it so the caller
    // can capture the result on the same edge that retires the last step.
    always_comb begin
        acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
        product_o = neg_q ? (~acc_step + 1'b1) : acc_step;
        done_o    = busy_q && (cnt_q == CNT_W'(W - 1));
        busy_o    = busy_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q   <= 1'b0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (start_i) begin
            busy_q   <= 1'b1;
            neg_q    <= a_i[W-1] ^ b_i[W-1];
            cnt_q    <= '0;
            mcand_q  <= {{W{1'b0}}, magnitude(a_i)};
            mplier_q <= magnitude(b_i);
            acc_q    <= '0;
        end else if (busy_q && step_i) begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            if (done_o) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipelined_alu.sv
// Handshaked ALU: single-cycle add/sub/compare/move, multi-cycle signed multiply,
// with result and flags held in an output register until consumed.
module pipelined_alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 8
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic                    enable_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OPCODE_WIDTH-1:0] opcode_in,
    input  logic [DATA_WIDTH-1:0]   alu_input1,
    input  logic [DATA_WIDTH-1:0]   alu_input2,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   alu_output,
    output logic                    overflow_flag,
    output logic                    carry_flag,
    output logic                    zero_flag,
    output logic                    sign_flag,
    output logic                    parity_flag,
    output logic                    illegal_op_flag
);

    localparam int W = DATA_WIDTH;

    state_e         state_q, state_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   result_q, result_d;
    flags_t         flags_q, flags_d;

    op_kind_e       op_kind;
    logic [W:0]     sum, diff;
    logic [W-1:0]   alu_result;
    logic           alu_overflow, alu_carry;

    logic           reg_free, transfer, consume;
    logic           mul_start, mul_step, mul_busy, mul_done;
    logic [2*W-1:0] mul_product;
    logic [W:0]     mul_upper;
    logic           mul_overflow;

    function automatic flags_t make_flags(input logic [W-1:0] r, input logic ovf,
                                          input logic cy, input logic ill);
        flags_t f;
        f.overflow = ovf;
        f.carry    = cy;
        f.zero     = (r == '0);
        f.sign     = r[W-1];
        f.parity   = ^r;
        f.illegal  = ill;
        return f;
    endfunction

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        op_kind = OP_ILLEGAL;
        case (opcode_in)
            OPCODE_WIDTH'(OPC_ADD), OPCODE_WIDTH'(OPC_ADDI): op_kind = OP_ADD;
            OPCODE_WIDTH'(OPC_SUB), OPCODE_WIDTH'(OPC_SUBI): op_kind = OP_SUB;
            OPCODE_WIDTH'(OPC_MUL):                          op_kind = OP_MUL;
            OPCODE_WIDTH'(OPC_EQ):                           op_kind = OP_EQ;
            OPCODE_WIDTH'(OPC_GT):                           op_kind = OP_GT;
            OPCODE_WIDTH'(OPC_MOV):                          op_kind = OP_MOV;
            default:                                         op_kind = OP_ILLEGAL;
        endcase
    end

    assign sum  = {1'b0, alu_input1} + {1'b0, alu_input2};
    assign diff = {1'b0, alu_input1} - {1'b0, alu_input2};

    always_comb begin
        alu_result   = '0;
        alu_overflow = 1'b0;
        alu_carry    = 1'b0;
        case (op_kind)
            OP_ADD: begin
                alu_result   = sum[W-1:0];
                alu_carry    = sum[W];
                alu_overflow = (alu_input1[W-1] == alu_input2[W-1]) &&
                               (sum[W-1] != alu_input1[W-1]);
            end
            OP_SUB: begin
                alu_result   = diff[W-1:0];
                alu_carry    = diff[W];
                alu_overflow = (alu_input1[W-1] != alu_input2[W-1]) &&
                               (diff[W-1] != alu_input1[W-1]);
            end
            OP_EQ:   alu_result = {{(W-1){1'b0}}, alu_input1 == alu_input2};
            OP_GT:   alu_result = {{(W-1){1'b0}}, $signed(alu_input1) > $signed(alu_input2)};
            OP_MOV:  alu_result = alu_input1;
            default: alu_result = '0;
        endcase
    end

    // The product fits the result width only if its top W+1 bits are a pure sign extension.
    assign mul_upper    = mul_product[2*W-1:W-1];
    assign mul_overflow = !((&mul_upper) || !(|mul_upper));

    assign reg_free  = !out_valid_q || out_ready;
    assign in_ready  = !reset_in && enable_in && (state_q == ST_IDLE) && reg_free;
    assign transfer  = in_valid && in_ready;
    assign consume   = out_valid_q && out_ready && enable_in;
    assign mul_start = transfer && (op_kind == OP_MUL);
    assign mul_step  = enable_in && (state_q == ST_MUL_BUSY) && mul_busy &&
                       (!mul_done || reg_free);

    seq_multiplier #(
        .W (W)
    ) u_mul (
        .clk_i     (clk_in),
        .rst_i     (reset_in),
        .start_i   (mul_start),
        .step_i    (mul_step),
        .a_i       (alu_input1),
        .b_i       (alu_input2),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        if (consume) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (transfer && (op_kind == OP_MUL)) begin
                    state_d = ST_MUL_BUSY;
                end else if (transfer) begin
                    out_valid_d = 1'b1;
                    result_d    = alu_result;
                    flags_d     = make_flags(alu_result, alu_overflow, alu_carry,
                                             op_kind == OP_ILLEGAL);
                end
            end
            ST_MUL_BUSY: begin
                if (mul_step && mul_done) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b1;
                    result_d    = mul_product[W-1:0];
                    flags_d     = make_flags(mul_product[W-1:0], mul_overflow,
                                             mul_overflow, 1'b0);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= FLAGS_RESET;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign alu_output      = result_q;
    assign overflow_flag   = flags_q.overflow;
    assign carry_flag      = flags_q.carry;
    assign zero_flag       = flags_q.zero;
    assign sign_flag       = flags_q.sign;
    assign parity_flag     = flags_q.parity;
    assign illegal_op_flag = flags_q.illegal;

endmodule

// File: tb/tb_pipelined_alu.sv
// Self-checking bench for pipelined_alu: directed handshake/latency/reset steps,
// then randomized traffic scored against an arithmetic reference model.
module tb_pipelined_alu;

    localparam int W  = 8;
    localparam int OW = 8;

    logic          clk_in = 1'b0;
    logic          reset_in;
    logic          enable_in;
    logic          in_valid;
    logic          in_ready;
    logic [OW-1:0] opcode_in;
    logic [W-1:0]  alu_input1;
    logic [W-1:0]  alu_input2;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  alu_output;
    logic          overflow_flag, carry_flag, zero_flag;
    logic          sign_flag, parity_flag, illegal_op_flag;

    // Expected result bundle: value then overflow, carry, zero, sign, parity, illegal.
    typedef struct packed {
        logic [7:0] res;
        logic       ovf;
        logic       carry;
        logic       zero;
        logic       sign;
        logic       parity;
        logic       ill;
    } exp_t;

    int   compared   = 0;
    int   mismatched = 0;
    int   bad;
    int   n;
    exp_t e;
    exp_t sb_q[$];

    localparam exp_t RESET_EXP = {8'h00, 6'b001000};

    pipelined_alu #(
        .DATA_WIDTH   (W),
        .OPCODE_WIDTH (OW)
    ) dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .enable_in       (enable_in),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .opcode_in       (opcode_in),
        .alu_input1      (alu_input1),
        .alu_input2      (alu_input2),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .alu_output      (alu_output),
        .overflow_flag   (overflow_flag),
        .carry_flag      (carry_flag),
        .zero_flag       (zero_flag),
        .sign_flag       (sign_flag),
        .parity_flag     (parity_flag),
        .illegal_op_flag (illegal_op_flag)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] obs14();
        return {alu_output, overflow_flag, carry_flag, zero_flag,
                sign_flag, parity_flag, illegal_op_flag};
    endfunction

    // Reference model: plain integer arithmetic on the signed/unsigned operand values.
    function automatic exp_t model(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        int   sa, sb, ua, ub, r;
        exp_t m;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = int'(a);
        ub = int'(b);
        m  = '0;
        r  = 0;
        case (op)
            8'd0, 8'd9: begin
                r       = sa + sb;
                m.carry = (ua + ub) > 255;
                m.ovf   = (r > 127) || (r < -128);
            end
            8'd1, 8'd10: begin
                r       = sa - sb;
                m.carry = ua < ub;
                m.ovf   = (r > 127) || (r < -128);
            end
            8'd2: begin
                r       = sa * sb;
                m.ovf   = (r > 127) || (r < -128);
                m.carry = m.ovf;
            end
            8'd3:    r = (sa == sb) ? 1 : 0;
            8'd4:    r = (sa > sb) ? 1 : 0;
            8'd11:   r = sa;
            default: m.ill = 1'b1;
        endcase
        m.res    = r[7:0];
        m.zero   = (m.res == 8'h00);
        m.sign   = m.res[7];
        m.parity = ^m.res;
        return m;
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Presents one op, waits (bounded) for in_ready, and returns 1 time unit after
    // the transfer edge with the input bus scrambled.
    task automatic send(input string tag, input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        int waits;
        in_valid   = 1'b1;
        opcode_in  = op;
        alu_input1 = a;
        alu_input2 = b;
        #1;
        waits = 0;
        while (!in_ready && waits < 50) begin
            tick();
            #1;
            waits++;
        end
        check({tag, "_accept"}, 32'(waits < 50), 32'd1);
        tick();
        in_valid   = 1'b0;
        opcode_in  = 8'($urandom);
        alu_input1 = 8'($urandom);
        alu_input2 = 8'($urandom);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Multiply latency: idle and not ready for W-1 edges, result after edge W.
    task automatic mul_wait(input string tag, input exp_t x);
        int early;
        early = 0;
        for (int i = 1; i < W; i++) begin
            tick();
            if (out_valid || in_ready) early++;
        end
        tick();
        check({tag, "_busy"}, 32'(early), 32'd0);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_val"}, 32'(obs14()), 32'(x));
    endtask

    initial begin
        reset_in   = 1'b1;
        enable_in  = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        opcode_in  = '0;
        alu_input1 = '0;
        alu_input2 = '0;
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_outputs", 32'(obs14()), 32'(RESET_EXP));
        tick();
        tick();
        reset_in = 1'b0;
        #1;
        check("post_rst_ready", 32'(in_ready), 32'd1);

        send("add", 8'd0, 8'd100, 8'd50);
        check("add_lat", 32'(out_valid), 32'd1);
        check("add_val", 32'(obs14()), 32'({8'h96, 6'b100100}));
        consume();

        send("sub", 8'd1, 8'd3, 8'd5);
        check("sub_lat", 32'(out_valid), 32'd1);
        check("sub_val", 32'(obs14()), 32'({8'hFE, 6'b010110}));
        consume();

        send("mul_neg", 8'd2, 8'hF9, 8'd9);
        mul_wait("mul_neg", {8'hC1, 6'b000110});
        consume();

        send("mul_ovf", 8'd2, 8'd16, 8'd16);
        mul_wait("mul_ovf", {8'h00, 6'b111000});
        consume();

        // Backpressure: a full register blocks the next op until the consumer takes it.
        send("bp1", 8'd0, 8'd1, 8'd1);
        check("bp1_val", 32'(obs14()), 32'({8'h02, 6'b000010}));
        in_valid   = 1'b1;
        opcode_in  = 8'd0;
        alu_input1 = 8'd2;
        alu_input2 = 8'd2;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (in_ready || !out_valid || alu_output !== 8'd2) bad++;
        end
        check("bp_hold", 32'(bad), 32'd0);
        check("bp_blocked", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        check("bp_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_swap_valid", 32'(out_valid), 32'd1);
        check("bp_swap_val", 32'(obs14()), 32'({8'h04, 6'b000010}));
        tick();
        out_ready = 1'b0;
        check("bp_drained", 32'(out_valid), 32'd0);

        send("illegal", 8'hFF, 8'd5, 8'd3);
        check("illegal_val", 32'(obs14()), 32'({8'h00, 6'b001001}));
        consume();
        send("eq", 8'd3, 8'd7, 8'd7);
        check("eq_val", 32'(obs14()), 32'({8'h01, 6'b000010}));
        consume();

        // Global stall mid-multiply freezes the counter; a stalled consume does nothing.
        send("mul_stall", 8'd2, 8'd3, 8'd3);
        tick();
        tick();
        enable_in = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid || in_ready) bad++;
        end
        enable_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid) bad++;
        end
        check("stall_frozen", 32'(bad), 32'd0);
        tick();
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_val", 32'(obs14()), 32'({8'h09, 6'b000000}));
        out_ready = 1'b1;
        enable_in = 1'b0;
        #1;
        check("stall_no_ready", 32'(in_ready), 32'd0);
        tick();
        check("stall_no_consume", 32'(out_valid), 32'd1);
        enable_in = 1'b1;
        tick();
        out_ready = 1'b0;
        check("stall_consumed", 32'(out_valid), 32'd0);

        // Asynchronous reset three cycles into a multiply abandons it.
        send("mul_rst", 8'd2, 8'd5, 8'd5);
        tick();
        tick();
        tick();
        #2;
        reset_in = 1'b1;
        #1;
        check("async_rst_outputs", 32'(obs14()), 32'(RESET_EXP));
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_ready", 32'(in_ready), 32'd0);
        tick();
        reset_in = 1'b0;
        #1;
        check("rst_release_ready", 32'(in_ready), 32'd1);
        bad = 0;
        for (int i = 0; i < W + 4; i++) begin
            tick();
            if (out_valid) bad++;
        end
        check("rst_no_stale", 32'(bad), 32'd0);

        // Randomized traffic with backpressure and stalls, scored in transfer order.
        for (int cyc = 0; cyc < 600; cyc++) begin
            int sel;
            sel        = int'($urandom_range(0, 8));
            case (sel)
                0: opcode_in = 8'd0;
                1: opcode_in = 8'd1;
                2: opcode_in = 8'd2;
                3: opcode_in = 8'd3;
                4: opcode_in = 8'd4;
                5: opcode_in = 8'd9;
                6: opcode_in = 8'd10;
                7: opcode_in = 8'd11;
                default: opcode_in = 8'($urandom);
            endcase
            alu_input1 = ($urandom_range(0, 4) == 0) ? 8'h80 : 8'($urandom);
            alu_input2 = ($urandom_range(0, 4) == 0) ? 8'h7F : 8'($urandom);
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            enable_in  = ($urandom_range(0, 7) != 0);
            #1;
            if (out_valid && out_ready && enable_in) begin
                check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("sb_result", 32'(obs14()), 32'(e));
                end
            end
            if (in_valid && in_ready) sb_q.push_back(model(opcode_in, alu_input1, alu_input2));
            tick();
        end

        in_valid  = 1'b0;
        enable_in = 1'b1;
        out_ready = 1'b1;
        #1;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            if (out_valid) begin
                e = sb_q.pop_front();
                check("drain_result", 32'(obs14()), 32'(e));
            end
            tick();
            #1;
            n++;
        end
        check("drain_empty", 32'(sb_q.size()), 32'd0);
        check("drain_no_extra", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pipelined_alu.md
# pipelined_alu

Parametrised, handshaked successor to the combinational tensor-core ALU. It accepts one operation per valid/ready transfer and executes signed add/subtract/compare/move in one cycle. It executes signed multiply over `DATA_WIDTH` cycles with an iterative shift-add engine. The result and flags are held in an output register until the consumer accepts them. It sits between the operand-fetch stage and register writeback.

## Interface
- `DATA_WIDTH`, 8: operand/result width in bits, two's complement, ≥ 2.
- `OPCODE_WIDTH`, 8: opcode width.
- `clk_in` input 1: clock; all state on rising edge.
- `reset_in` input 1: asynchronous, active-high reset.
- `enable_in` input 1: global stall. When low, all state is frozen and `in_ready` is 0.
- `in_valid` input 1: operation presented.
- `in_ready` output 1: block can accept an operation this cycle.
- `opcode_in` input `OPCODE_WIDTH`: operation code.
- `alu_input1`, `alu_input2` input `DATA_WIDTH`: signed operands.
- `out_valid` output 1: result register holds an unconsumed result.
- `out_ready` input 1: consumer accepts the result.
- `alu_output` output `DATA_WIDTH`: signed result.
- `overflow_flag`, `carry_flag`, `zero_flag`, `sign_flag`, `parity_flag`, `illegal_op_flag` output 1 each: registered with the result.

## Operation
- Opcodes: ADD=0, SUB=1, MUL=2, EQ=3, GT=4, ADDI=9, SUBI=10, MOV=11. Any other value is illegal.
- ADD/ADDI: result is the low `DATA_WIDTH` bits of `a+b`. carry = unsigned carry-out. overflow = both operand signs equal and result sign differs.
- SUB/SUBI: result is `a−b`. carry = unsigned borrow (a <u b). overflow = operand signs differ and result sign differs from a.
- MUL: full `2·DATA_WIDTH` signed product. The engine works on operand magnitudes (|min| fits unsigned) and negates the product if the operand signs differ. result = low half. overflow = carry = product outside [−2^(W−1), 2^(W−1)−1].
- EQ: result 1 if a==b, else 0. GT: result 1 if a>b (signed), else 0. MOV: result = a. For EQ/GT/MOV, overflow = carry = 0.
- Illegal opcode: result 0, overflow 0, carry 0, `illegal_op_flag` 1. `illegal_op_flag` is 0 for all legal opcodes.
- zero = (result==0). sign = result MSB. parity = XOR of all result bits. All three are computed for every opcode.
- FSM states:
  - IDLE: a transfer of a non-MUL op loads the result register. A transfer of a MUL op goes to MUL_BUSY with the iteration counter = 0.
  - MUL_BUSY: one partial-product step per cycle. At counter = `DATA_WIDTH`−1, load the result register and go to IDLE.
- `in_ready` = enable_in ∧ state==IDLE ∧ (¬out_valid ∨ out_ready).
- A transfer happens when in_valid ∧ in_ready. Operands and opcode are captured on that edge; the inputs may change afterwards.
- The output register clears `out_valid` on out_valid ∧ out_ready ∧ enable_in, unless it is reloaded on the same edge.

## Timing
- Reset values: state IDLE, `out_valid` 0, `alu_output` 0, overflow/carry/sign/parity/illegal_op 0, `zero_flag` 1. `in_ready` is 0 while reset is asserted.
- Non-MUL latency: transfer at edge k → `out_valid` high after edge k.
- MUL latency: transfer at edge k → `out_valid` high after edge k+`DATA_WIDTH`. `in_ready` is 0 throughout.
- Simultaneous consume and accept at edge k: the new result replaces the old one and `out_valid` stays 1. Full throughput is one non-MUL op per cycle.
- Backpressure: if `out_valid` ∧ ¬`out_ready`, the result and flags are held stable and `in_ready` is 0. A MUL completing while the register is full waits in MUL_BUSY at the final count and loads when the register frees.
- `enable_in` low: counter, FSM and output register are all frozen. No transfer or consume occurs.
- Reset mid-MUL: the operation is abandoned, reset values apply immediately, and no result is produced.

## Structure
- Package `alu_pkg`: opcode `localparam`s or an enum, the FSM state enum, and a flag-bundle struct.
- Sub-module `seq_multiplier`:
  - Inputs: start, operands. Outputs: busy, done, `2·DATA_WIDTH` signed product.
  - Handles magnitude conversion and sign fix-up internally.
  - The top level owns the handshake, the single-cycle datapath and the flag generation.

## Test plan
(DATA_WIDTH=8)
- ADD 100+50 → result 0x96 (−106), overflow 1, carry 0, sign 1, `out_valid` one cycle after transfer.
- SUB 3−5 → 0xFE, carry 1, overflow 0, zero 0, parity 1.
- MUL −7×9 → 0xC1 (−63), overflow 0, `out_valid` 8 cycles after transfer, `in_ready` low meanwhile. MUL 16×16 → 0x00, overflow 1, carry 1, zero 1.
- Backpressure: ADD 1+1, then ADD 2+2 presented with `out_ready` held low → result 2 held and `in_ready` 0. Raise `out_ready` → 2 consumed and 4 loaded on the same edge; each result seen exactly once.
- Opcode 0xFF with a=5 → result 0, `illegal_op_flag` 1, zero 1. A following EQ 7,7 → result 1, illegal 0.
- Assert `reset_in` asynchronously 3 cycles into MUL 5×5 → outputs go to reset values before the next edge. After release, `in_ready` is 1 and no stale result appears.
